slice_seq: RTL and testbench

Instruction-cycle and front-panel sequencer for the bit-slice datapath. It drives the per-slice control strobes shared by every slice: A/X/P/S register read and write, X input select, P increment and load, and deposit. It also runs the memory read/write handshake. It sits between the panel switches, the external IR/memory, and the slice column, and is the only source of those strobes.

---
 rtl/slice_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_slice_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/slice_seq.sv
// Instruction-cycle and front-panel sequencer for the bit-slice column.
// All strobes are registered and decoded from the state being entered.
module slice_seq #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ir,
  input  logic       x_zero,
  input  logic       run_req,
  input  logic       step_req,
  input  logic       dep_req,
  input  logic       exam_req,
  input  logic       halt_req,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       wri,
  output logic       wra,
  output logic       rda,
  output logic       wrx,
  output logic       rdx,
  output logic       rdp,
  output logic       incp,
  output logic       wrs,
  output logic       dep,
  output logic       nwrp,
  output logic [3:0] xin_sel,
  output logic       running
);

  if (ADDR_W == 0) begin : g_addr_w_check
    $error("ADDR_W must be nonzero");
  end

  typedef enum logic [2:0] {
    StHalt, StFReq, StFLat, StXDec, StXReq, StXFin, StPReq, StPFin
  } state_e;

  localparam logic [2:0] OpLdx = 3'd1;
  localparam logic [2:0] OpLda = 3'd2;

  localparam logic [3:0] XinShift = 4'b0010;
  localparam logic [3:0] XinDbus  = 4'b1000;

  state_e     state_q;
  logic       run_q;
  logic       halt_q;
  logic       pwr_q;   // panel access is a deposit (write) rather than examine
  logic [2:0] op_q;
  logic       xdone_q; // X_REQ ack seen; current cycle is the data-consume cycle

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHalt;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      pwr_q   <= 1'b0;
      op_q    <= 3'd0;
      xdone_q <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      wri     <= 1'b0;
      wra     <= 1'b0;
      rda     <= 1'b0;
      wrx     <= 1'b0;
      rdx     <= 1'b0;
      rdp     <= 1'b0;
      incp    <= 1'b0;
      wrs     <= 1'b0;
      dep     <= 1'b0;
      nwrp    <= 1'b1;
      xin_sel <= 4'b0000;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      wri     <= 1'b0;
      wra     <= 1'b0;
      rda     <= 1'b0;
      wrx     <= 1'b0;
      rdx     <= 1'b0;
      rdp     <= 1'b0;
      incp    <= 1'b0;
      wrs     <= 1'b0;
      dep     <= 1'b0;
      nwrp    <= 1'b1;
      xin_sel <= 4'b0000;

      if (halt_req && state_q != StHalt) halt_q <= 1'b1;

      unique case (state_q)
        StHalt: begin
          if (run_req || step_req) begin
            run_q   <= run_req;
            state_q <= StFReq;
            rdp     <= 1'b1;
            mem_rd  <= 1'b1;
          end else if (dep_req) begin
            pwr_q   <= 1'b1;
            state_q <= StPReq;
            rdp     <= 1'b1;
            dep     <= 1'b1;
            mem_wr  <= 1'b1;
          end else if (exam_req) begin
            pwr_q   <= 1'b0;
            state_q <= StPReq;
            rdp     <= 1'b1;
            mem_rd  <= 1'b1;
          end
        end

        StPReq: begin
          if (mem_ack) begin
            state_q <= StPFin;
            incp    <= 1'b1;
            wra     <= ~pwr_q;
          end else begin
            rdp    <= 1'b1;
            dep    <= pwr_q;
            mem_wr <= pwr_q;
            mem_rd <= ~pwr_q;
          end
        end

        StPFin: begin
          state_q <= StHalt;
          halt_q  <= 1'b0;
        end

        StFReq: begin
          if (mem_ack) begin
            state_q <= StFLat;
            wri     <= 1'b1;
            incp    <= 1'b1;
          end else begin
            rdp    <= 1'b1;
            mem_rd <= 1'b1;
          end
        end

        StFLat: state_q <= StXDec;

        StXDec: begin
          op_q    <= ir;
          xdone_q <= 1'b0;
          state_q <= StXFin;
          unique case (ir)
            3'd0: ;
            3'd1: begin
              state_q <= StXReq;
              rdp     <= 1'b1;
              mem_rd  <= 1'b1;
            end
            3'd2: begin
              state_q <= StXReq;
              rdx     <= 1'b1;
              mem_rd  <= 1'b1;
            end
            3'd3: begin
              state_q <= StXReq;
              rdx     <= 1'b1;
              rda     <= 1'b1;
              mem_wr  <= 1'b1;
            end
            3'd4: nwrp <= 1'b0;
            3'd5: nwrp <= ~x_zero;
            3'd6: begin
              wrx     <= 1'b1;
              wrs     <= 1'b1;
              xin_sel <= XinShift;
            end
            3'd7: run_q <= 1'b0;
          endcase
        end

        StXReq: begin
          if (xdone_q) begin
            state_q <= StXFin;
            xdone_q <= 1'b0;
            incp    <= (op_q == OpLdx);
          end else if (mem_ack) begin
            xdone_q <= 1'b1;
            wrx     <= (op_q == OpLdx);
            xin_sel <= (op_q == OpLdx) ? XinDbus : 4'b0000;
            wra     <= (op_q == OpLda);
          end else begin
            case (op_q)
              OpLdx: begin
                rdp    <= 1'b1;
                mem_rd <= 1'b1;
              end
              OpLda: begin
                rdx    <= 1'b1;
                mem_rd <= 1'b1;
              end
              default: begin
                rdx    <= 1'b1;
                rda    <= 1'b1;
                mem_wr <= 1'b1;
              end
            endcase
          end
        end

        StXFin: begin
          halt_q <= 1'b0;
          if (run_q && !halt_q && !halt_req) begin
            state_q <= StFReq;
            rdp     <= 1'b1;
            mem_rd  <= 1'b1;
          end else begin
            state_q <= StHalt;
            run_q   <= 1'b0;
          end
        end

        default: state_q <= StHalt;
      endcase
    end
  end

  assign running = run_q | (state_q != StHalt);

endmodule

// File: tb/tb_slice_seq.sv
// Cycle-accurate check of slice_seq strobes against a table of expected
// output vectors, fed through a scoreboard queue.
module tb_slice_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ir;
  logic       x_zero, run_req, step_req, dep_req, exam_req, halt_req, mem_ack;
  logic       mem_rd, mem_wr, wri, wra, rda, wrx, rdx, rdp, incp, wrs, dep, nwrp;
  logic [3:0] xin_sel;
  logic       running;

  always #5 clk = ~clk;

  slice_seq #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .x_zero   (x_zero),
    .run_req  (run_req),
    .step_req (step_req),
    .dep_req  (dep_req),
    .exam_req (exam_req),
    .halt_req (halt_req),
    .mem_ack  (mem_ack),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .wri      (wri),
    .wra      (wra),
    .rda      (rda),
    .wrx      (wrx),
    .rdx      (rdx),
    .rdp      (rdp),
    .incp     (incp),
    .wrs      (wrs),
    .dep      (dep),
    .nwrp     (nwrp),
    .xin_sel  (xin_sel),
    .running  (running)
  );

  wire [16:0] obs = {running, mem_rd, mem_wr, wri, wra, rda, wrx, rdx, rdp, incp, wrs, dep,
                     nwrp, xin_sel};

  // Expected-output bits; NPL marks nwrp driven low.
  localparam logic [16:0] RUN = 17'h10000, MRD = 17'h08000, MWR = 17'h04000, WRI = 17'h02000;
  localparam logic [16:0] WRA = 17'h01000, RDA = 17'h00800, WRX = 17'h00400, RDX = 17'h00200;
  localparam logic [16:0] RDP = 17'h00100, INCP = 17'h00080, WRS = 17'h00040, DEP = 17'h00020;
  localparam logic [16:0] NPL = 17'h00010, XSH = 17'h00002, XDB = 17'h00008, NONE = 17'h0;

  // Input bits: {rst, run, step, dep, exam, halt, ack, x_zero, ir[2:0]}
  localparam logic [10:0] I_RST = 11'h400, I_RUN = 11'h200, I_STEP = 11'h100, I_DEP = 11'h080;
  localparam logic [10:0] I_EXAM = 11'h040, I_HALT = 11'h020, I_ACK = 11'h010, I_XZ = 11'h008;
  localparam logic [10:0] I_IDLE = 11'h000;

  typedef struct {
    logic [10:0] in;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic add(input logic [10:0] in, input logic [16:0] e);
    vec_t v;
    v.in  = in;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic [10:0] in, input logic [16:0] e, input string tag);
    logic [16:0] got, want;
    @(negedge clk);
    {rst, run_req, step_req, dep_req, exam_req, halt_req, mem_ack, x_zero, ir} = in;
    exp_q.push_back(e ^ NPL);
    @(posedge clk);
    #1;
    got  = obs;
    want = exp_q.pop_front();
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
    n_total++;
    if (!((incp && !nwrp) || (wrx && wra))) n_pass++;
    else $display("FAIL %s excl: got incp=%b nwrp=%b wrx=%b wra=%b want no overlap", tag,
                  incp, nwrp, wrx, wra);
  endtask

  initial begin
    int nwait;

    // Reset, then idle with stray acks
    add(I_RST, NONE);
    add(I_RST, NONE);
    for (int i = 0; i < 10; i++) add((i % 3 == 1) ? I_ACK : I_IDLE, NONE);
    // Deposit with two wait cycles; run_req ignored outside HALT
    add(I_DEP, RUN | RDP | DEP | MWR);
    add(I_RUN, RUN | RDP | DEP | MWR);
    add(I_IDLE, RUN | RDP | DEP | MWR);
    add(I_ACK, RUN | INCP);
    add(I_IDLE, NONE);
    // Examine, zero wait
    add(I_EXAM, RUN | RDP | MRD);
    add(I_ACK, RUN | INCP | WRA);
    add(I_IDLE, NONE);
    // dep beats exam
    add(I_DEP | I_EXAM, RUN | RDP | DEP | MWR);
    add(I_ACK, RUN | INCP);
    add(I_IDLE, NONE);
    // Step LDX, zero wait
    add(I_STEP | 11'd1, RUN | RDP | MRD);
    add(I_ACK | 11'd1, RUN | WRI | INCP);
    add(11'd1, RUN);
    add(11'd1, RUN | RDP | MRD);
    add(I_ACK | 11'd1, RUN | WRX | XDB);
    add(11'd1, RUN | INCP);
    add(11'd1, NONE);
    // Run JZ: taken then not taken, then HLT stops it
    add(I_RUN | I_STEP | I_XZ | 11'd5, RUN | RDP | MRD);
    add(I_ACK | I_XZ | 11'd5, RUN | WRI | INCP);
    add(I_XZ | 11'd5, RUN);
    add(I_XZ | 11'd5, RUN | NPL);
    add(I_XZ | 11'd5, RUN | RDP | MRD);
    add(I_ACK | 11'd5, RUN | WRI | INCP);
    add(11'd5, RUN);
    add(11'd5, RUN);
    add(11'd5, RUN | RDP | MRD);
    add(I_ACK | 11'd7, RUN | WRI | INCP);
    add(11'd7, RUN);
    add(11'd7, RUN);
    add(11'd7, NONE);
    // Run STA with halt_req during the write wait
    add(I_RUN | 11'd3, RUN | RDP | MRD);
    add(I_ACK | 11'd3, RUN | WRI | INCP);
    add(11'd3, RUN);
    add(11'd3, RUN | RDX | RDA | MWR);
    add(I_HALT | 11'd3, RUN | RDX | RDA | MWR);
    add(11'd3, RUN | RDX | RDA | MWR);
    add(I_ACK | 11'd3, RUN);
    add(11'd3, RUN);
    add(11'd3, NONE);
    add(11'd3, NONE);
    // Step LDA
    add(I_STEP | 11'd2, RUN | RDP | MRD);
    add(I_ACK | 11'd2, RUN | WRI | INCP);
    add(11'd2, RUN);
    add(11'd2, RUN | RDX | MRD);
    add(I_ACK | 11'd2, RUN | WRA);
    add(11'd2, RUN);
    add(11'd2, NONE);
    // Step SHX
    add(I_STEP | 11'd6, RUN | RDP | MRD);
    add(I_ACK | 11'd6, RUN | WRI | INCP);
    add(11'd6, RUN);
    add(11'd6, RUN | WRX | WRS | XSH);
    add(11'd6, NONE);
    // Step JMP with one fetch wait
    add(I_STEP | 11'd4, RUN | RDP | MRD);
    add(11'd4, RUN | RDP | MRD);
    add(I_ACK | 11'd4, RUN | WRI | INCP);
    add(11'd4, RUN);
    add(11'd4, RUN | NPL);
    add(11'd4, NONE);
    // Reset during fetch request; late ack ignored
    add(I_STEP, RUN | RDP | MRD);
    add(I_RST, NONE);
    add(I_ACK, NONE);
    add(I_IDLE, NONE);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

    // Examine with a random number of wait cycles
    nwait = $urandom_range(3, 6);
    apply(I_EXAM, RUN | RDP | MRD, "exam_req");
    for (int w = 0; w < nwait; w++) apply(I_IDLE, RUN | RDP | MRD, $sformatf("exam_wait%0d", w));
    apply(I_ACK, RUN | INCP | WRA, "exam_ack");
    apply(I_IDLE, NONE, "exam_done");

    // halt_req during X_DEC stops a running NOP; latch then clears for the next run
    apply(I_RUN, RUN | RDP | MRD, "h_fetch");
    apply(I_ACK, RUN | WRI | INCP, "h_lat");
    apply(I_HALT, RUN, "h_dec");
    apply(I_IDLE, RUN, "h_fin");
    apply(I_IDLE, NONE, "h_halted");
    apply(I_RUN, RUN | RDP | MRD, "r_fetch");
    apply(I_ACK, RUN | WRI | INCP, "r_lat");
    apply(I_IDLE, RUN, "r_dec");
    apply(I_IDLE, RUN, "r_fin");
    apply(I_IDLE, RUN | RDP | MRD, "r_refetch");
    apply(I_HALT, RUN | RDP | MRD, "r_halt_in_fetch");
    apply(I_ACK, RUN | WRI | INCP, "r_lat2");
    apply(I_IDLE, RUN, "r_dec2");
    apply(I_IDLE, RUN, "r_fin2");
    apply(I_IDLE, NONE, "r_halted");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
